imm_extend_pipe: RTL

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_pkg.sv | 13 +
 rtl/imm_extend_comb.sv | 36 +++
 rtl/imm_extend_pipe.sv | 88 ++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared mode encodings for the immediate extender
package imm_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_SIGN   = 2'd0,
        MODE_ZERO   = 2'd1,
        MODE_UPPER  = 2'd2,
        MODE_BRANCH = 2'd3
    } imm_mode_e;

endpackage

// File: rtl/imm_extend_comb.sv
// rtl/imm_extend_comb.sv - combinational immediate extension and branch target
module imm_extend_comb
    import imm_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic [IN_W-1:0]   imm,
    input  logic [MODE_W-1:0] mode,
    input  logic [OUT_W-1:0]  pc,
    output logic [OUT_W-1:0]  ext,
    output logic [OUT_W-1:0]  target
);

    logic [OUT_W-1:0] sext;

    // Select the extension by mode; target is pc unless branching
    always_comb begin
        sext             = {OUT_W{imm[IN_W-1]}};
        sext[IN_W-1:0]   = imm;
        ext              = sext;
        target           = pc;
        case (imm_mode_e'(mode))
            MODE_SIGN:   ext = sext;
            MODE_ZERO:   ext = OUT_W'(imm);
            MODE_UPPER:  ext = OUT_W'(imm) << (OUT_W - IN_W);
            MODE_BRANCH: begin
                ext    = sext << SHIFT;
                target = pc + (sext << SHIFT);
            end
            default:     ext = sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - immediate extender with output register and skid buffer
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_imm,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [OUT_W-1:0]  in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_ext,
    output logic [OUT_W-1:0]  out_target
);

    logic [OUT_W-1:0] calc_ext;
    logic [OUT_W-1:0] calc_target;
    logic             skid_valid;
    logic [OUT_W-1:0] skid_ext;
    logic [OUT_W-1:0] skid_target;
    logic             accept;
    logic             out_free;

    imm_extend_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_comb (
        .imm    (in_imm),
        .mode   (in_mode),
        .pc     (in_pc),
        .ext    (calc_ext),
        .target (calc_target)
    );

    // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;

    // Output register: refill from skid first to keep acceptance order, else from the extender
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_ext    <= '0;
            out_target <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_ext    <= skid_ext;
                out_target <= skid_target;
            end else if (accept) begin
                out_valid  <= 1'b1;
                out_ext    <= calc_ext;
                out_target <= calc_target;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Skid register: catches an accepted result while the output register is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_valid  <= 1'b0;
            skid_ext    <= '0;
            skid_target <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (skid_valid && out_free) begin
            skid_valid <= 1'b0;
        end else if (accept && !out_free) begin
            skid_valid  <= 1'b1;
            skid_ext    <= calc_ext;
            skid_target <= calc_target;
        end
    end

endmodule
